aes_dec: RTL and testbench

AES_DEC -- requirements
Module: aes_dec

---
 rtl/aes_dec.sv | 256 +++++++++++++++++++++++++
 tb/tb_aes_dec.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/aes_dec.sv
// aes_dec: iterative AES-128/192/256 block decryptor, one word of key schedule and one
// inverse round per cycle. Optional macro AES_DEC_KEY_CACHE_EN keeps the last schedule.

module aes_dec_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };
    // Entry a sits at bits [(255-a)*8 +: 8]; 255-a is simply ~a.
    assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

module aes_dec_inv_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [2047:0] TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };
    assign y = TABLE[{~a, 3'b000} +: 8];
endmodule

module aes_dec #(
    parameter int KEY_SIZE = 128
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [127:0]        ct,
    input  logic [KEY_SIZE-1:0] key,
    output logic [127:0]        pt,
    output logic                done
);
    localparam int NK = KEY_SIZE / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);
    localparam logic [5:0] NK_W   = 6'(NK);
    localparam logic [5:0] LAST_W = 6'(NW - 1);
    localparam logic [2:0] NK_M1  = 3'(NK - 1);
    localparam logic [3:0] NR_R   = 4'(NR);

    typedef enum logic [1:0] {IDLE, KEYEXP, WHITEN, ROUND} state_e;

    state_e         state_q, state_d;
    logic [127:0]   ct_q, ct_d;
    logic [127:0]   st_q, st_d;
    logic [127:0]   pt_q, pt_d;
    logic           done_q, done_d;
    logic [3:0]     rnd_q, rnd_d;
    logic [5:0]     wcnt_q, wcnt_d;
    logic [2:0]     kmod_q, kmod_d;
    logic [7:0]     rcon_q, rcon_d;
    logic [31:0]    rk_q [NW];

    logic           cache_hit;
    logic           key_load;
    logic [31:0]    prev_w, back_w, sub_in, sub_out, new_w;
    logic [127:0]   rk_round, rk_whiten, isr, isb, ark, imc, round_out;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
        logic [7:0] a [4];
        logic [7:0] m9 [4], m11 [4], m13 [4], m14 [4];
        for (int i = 0; i < 4; i++) begin
            logic [7:0] x2, x4, x8;
            a[i] = c[31-8*i -: 8];
            x2 = xtime(a[i]);
            x4 = xtime(x2);
            x8 = xtime(x4);
            m9[i]  = x8 ^ a[i];
            m11[i] = x8 ^ x2 ^ a[i];
            m13[i] = x8 ^ x4 ^ a[i];
            m14[i] = x8 ^ x4 ^ x2;
        end
        return {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
    endfunction

`ifdef AES_DEC_KEY_CACHE_EN
    // The first NK schedule words are the last expanded key, so they double as the tag.
    logic                cache_vld_q, cache_vld_d;
    logic [KEY_SIZE-1:0] cached_key;
    always_comb begin
        cached_key = '0;
        for (int k = 0; k < NK; k++) cached_key[KEY_SIZE-1-32*k -: 32] = rk_q[6'(k)];
    end
    assign cache_hit = cache_vld_q && (cached_key == key);
`else
    assign cache_hit = 1'b0;
`endif

    // Key schedule word generator.
    assign prev_w = rk_q[wcnt_q - 6'd1];
    assign back_w = rk_q[wcnt_q - NK_W];
    assign sub_in = (kmod_q == 3'd0) ? {prev_w[23:0], prev_w[31:24]} : prev_w;

    for (genvar b = 0; b < 4; b++) begin : g_sb
        aes_dec_sbox u_sb (.a(sub_in[31-8*b -: 8]), .y(sub_out[31-8*b -: 8]));
    end

    always_comb begin
        if (kmod_q == 3'd0)              new_w = back_w ^ sub_out ^ {rcon_q, 24'h0};
        else if (NK == 8 && kmod_q == 3'd4) new_w = back_w ^ sub_out;
        else                             new_w = back_w ^ prev_w;
    end

    // Inverse round datapath: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
    always_comb begin
        isr       = '0;
        rk_round  = '0;
        rk_whiten = '0;
        for (int c = 0; c < 4; c++) begin
            rk_round[127-32*c -: 32]  = rk_q[{rnd_q - 4'd1, 2'(c)}];
            rk_whiten[127-32*c -: 32] = rk_q[6'(4*NR + c)];
            for (int r = 0; r < 4; r++)
                isr[127-8*(r+4*c) -: 8] = st_q[127-8*(r+4*((c-r)&3)) -: 8];
        end
    end

    for (genvar b = 0; b < 16; b++) begin : g_isb
        aes_dec_inv_sbox u_isb (.a(isr[127-8*b -: 8]), .y(isb[127-8*b -: 8]));
    end

    assign ark = isb ^ rk_round;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        assign imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
    end

    assign round_out = (rnd_q == 4'd1) ? ark : imc;
    assign key_load  = (state_q == IDLE) && start && !cache_hit;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        ct_d    = ct_q;
        st_d    = st_q;
        pt_d    = pt_q;
        done_d  = 1'b0;
        rnd_d   = rnd_q;
        wcnt_d  = wcnt_q;
        kmod_d  = kmod_q;
        rcon_d  = rcon_q;
`ifdef AES_DEC_KEY_CACHE_EN
        cache_vld_d = cache_vld_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    ct_d = ct;
                    if (cache_hit) begin
                        state_d = WHITEN;
                    end else begin
                        state_d = KEYEXP;
                        wcnt_d  = NK_W;
                        kmod_d  = 3'd0;
                        rcon_d  = 8'h01;
`ifdef AES_DEC_KEY_CACHE_EN
                        cache_vld_d = 1'b0;
`endif
                    end
                end
            end
            KEYEXP: begin
                wcnt_d = wcnt_q + 6'd1;
                kmod_d = (kmod_q == NK_M1) ? 3'd0 : kmod_q + 3'd1;
                if (kmod_q == 3'd0) rcon_d = xtime(rcon_q);
                if (wcnt_q == LAST_W) begin
                    state_d = WHITEN;
`ifdef AES_DEC_KEY_CACHE_EN
                    cache_vld_d = 1'b1;
`endif
                end
            end
            WHITEN: begin
                st_d    = ct_q ^ rk_whiten;
                rnd_d   = NR_R;
                state_d = ROUND;
            end
            ROUND: begin
                st_d  = round_out;
                rnd_d = rnd_q - 4'd1;
                if (rnd_q == 4'd1) begin
                    pt_d    = round_out;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ct_q    <= '0;
            st_q    <= '0;
            pt_q    <= '0;
            done_q  <= 1'b0;
            rnd_q   <= '0;
            wcnt_q  <= '0;
            kmod_q  <= '0;
            rcon_q  <= '0;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_vld_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ct_q    <= ct_d;
            st_q    <= st_d;
            pt_q    <= pt_d;
            done_q  <= done_d;
            rnd_q   <= rnd_d;
            wcnt_q  <= wcnt_d;
            kmod_q  <= kmod_d;
            rcon_q  <= rcon_d;
`ifdef AES_DEC_KEY_CACHE_EN
            cache_vld_q <= cache_vld_d;
`endif
        end
    end

    // NOTE: the schedule array is never read before it is written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (key_load) begin
            for (int k = 0; k < NK; k++) rk_q[6'(k)] <= key[KEY_SIZE-1-32*k -: 32];
        end else if (state_q == KEYEXP) begin
            rk_q[wcnt_q] <= new_w;
        end
    end

    assign pt   = pt_q;
    assign done = done_q;
endmodule

// File: tb/tb_aes_dec.sv
// tb_aes_dec: directed FIPS-197 style vectors on 128/192/256-bit instances plus
// abort, ignored-start and back-to-back sequences.

module tb_aes_dec;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] ct;
    logic [255:0] key_v;
    logic         start_a [3];
    logic [127:0] pt_a [3];
    logic         done_a [3];
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    aes_dec #(.KEY_SIZE(128)) u_dut128 (.clk(clk), .rst(rst), .start(start_a[0]), .ct(ct),
        .key(key_v[255:128]), .pt(pt_a[0]), .done(done_a[0]));
    aes_dec #(.KEY_SIZE(192)) u_dut192 (.clk(clk), .rst(rst), .start(start_a[1]), .ct(ct),
        .key(key_v[255:64]), .pt(pt_a[1]), .done(done_a[1]));
    aes_dec #(.KEY_SIZE(256)) u_dut256 (.clk(clk), .rst(rst), .start(start_a[2]), .ct(ct),
        .key(key_v), .pt(pt_a[2]), .done(done_a[2]));

    typedef struct {
        int           sel;
        logic [127:0] ct;
        logic [255:0] key;
        logic [127:0] pt;
        int           lat;
        string        name;
    } vec_t;

    vec_t vecs [5];

`ifdef AES_DEC_KEY_CACHE_EN
    localparam int B2B_LAT = 11;
`else
    localparam int B2B_LAT = 51;
`endif

    localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A    = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_A   = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [127:0] CT_B    = 128'h29c3505f571420f6402299b31a02d73a;
    localparam logic [255:0] KEY_B   = {128'h5468617473206d79204b756e67204675, 128'h0};
    localparam logic [127:0] PT_B    = 128'h54776f204f6e65204e696e652054776f;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at #1 after an edge; returns #1 after the edge that sampled start.
    task automatic pulse_start(input int sel, input logic [127:0] c, input logic [255:0] k);
        ct           = c;
        key_v        = k;
        start_a[sel] = 1'b1;
        @(posedge clk);
        #1;
        start_a[sel] = 1'b0;
    endtask

    // Counts edges until done; lat = 0 means the budget expired.
    task automatic wait_done(input int sel, input int budget, output int lat);
        lat = 0;
        for (int i = 1; i <= budget; i++) begin
            @(posedge clk);
            #1;
            if (done_a[sel]) begin
                lat = i;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        int  lat2;
        bit  seen;

        vecs[0] = '{0, CT_A, KEY_A, PT_FIPS, 51, "fips128"};
        vecs[1] = '{0, CT_B, KEY_B, PT_B, 51, "two_one_nine_two"};
        vecs[2] = '{1, 128'hdda97ca4864cdfe06eaf70a0ec0d7191,
                    {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                    PT_FIPS, 59, "fips192"};
        vecs[3] = '{2, 128'h8ea2b7ca516745bfeafc49904b496089,
                    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                    PT_FIPS, 67, "fips256"};
        vecs[4] = '{0, 128'h3ad77bb40d7a3660a89ecaf32466ef97,
                    {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
                    128'h6bc1bee22e409f96e93d7e117393172a, 51, "sp800_ecb128"};

        rst   = 1'b1;
        ct    = '0;
        key_v = '0;
        for (int i = 0; i < 3; i++) start_a[i] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_pt%0d", i), pt_a[i], 128'h0);
            check($sformatf("reset_done%0d", i), 128'(done_a[i]), 128'h0);
        end

        for (int v = 0; v < 5; v++) begin
            pulse_start(vecs[v].sel, vecs[v].ct, vecs[v].key);
            wait_done(vecs[v].sel, 200, lat);
            check({vecs[v].name, "_latency"}, 128'(lat), 128'(vecs[v].lat));
            check({vecs[v].name, "_pt"}, pt_a[vecs[v].sel], vecs[v].pt);
            @(posedge clk);
            #1;
            check({vecs[v].name, "_done_one_cycle"}, 128'(done_a[vecs[v].sel]), 128'h0);
            check({vecs[v].name, "_pt_hold"}, pt_a[vecs[v].sel], vecs[v].pt);
        end

        // A start pulse with a different ct in the middle of key expansion is ignored.
        pulse_start(0, CT_A, KEY_A);
        repeat (20) @(posedge clk);
        #1;
        ct         = CT_B;
        start_a[0] = 1'b1;
        @(posedge clk);
        #1;
        start_a[0] = 1'b0;
        wait_done(0, 200, lat);
        check("ignored_start_latency", 128'(lat == 0 ? 0 : lat + 21), 128'd51);
        check("ignored_start_pt", pt_a[0], PT_FIPS);

        // Reset mid-operation: pt clears, no done, then a fresh run completes.
        pulse_start(0, CT_B, KEY_B);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_pt_cleared", pt_a[0], 128'h0);
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (done_a[0]) seen = 1'b1;
        end
        check("abort_no_done", 128'(seen), 128'h0);
        pulse_start(0, CT_A, KEY_A);
        wait_done(0, 200, lat);
        check("after_abort_latency", 128'(lat), 128'd51);
        check("after_abort_pt", pt_a[0], PT_FIPS);

        // Back-to-back with the same key; the second start lands in the done cycle.
        pulse_start(0, CT_B, KEY_B);
        wait_done(0, 200, lat);
        check("b2b_first_latency", 128'(lat), 128'd51);
        check("b2b_first_pt", pt_a[0], PT_B);
        pulse_start(0, CT_B, KEY_B);
        wait_done(0, 200, lat2);
        check("b2b_second_latency", 128'(lat2), 128'(B2B_LAT));
        check("b2b_second_pt", pt_a[0], PT_B);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
